// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG instruction/data register bank.
package jtag_pkg;

   // Default instruction opcodes for a 4-bit instruction register.
   localparam logic [3:0]  OP_BYPASS      = 4'b1111;
   localparam logic [3:0]  OP_IDCODE      = 4'b0001;
   localparam logic [3:0]  OP_USER        = 4'b1000;

   // Fixed low bits loaded into the IR on Capture-IR. The remaining upper bits load as zero.
   localparam logic [1:0]  IR_CAPTURE_PAT = 2'b01;

   localparam logic [31:0] DEF_IDCODE     = 32'h1000_0001;

   // Data register selected by the current instruction.
   typedef enum logic [1:0] {
      SEL_BYPASS,
      SEL_IDCODE,
      SEL_USER
   } dr_sel_e;

endpackage

// File: rtl/jtag_tdr_bank_if.sv
// TAP-controller-to-register-bank link: scan strobes and TDI in, TDO/TDO_EN back.
interface jtag_tdr_bank_if;

   logic TDI;
   logic TAP_RST;
   logic CAPTUREIR;
   logic SHIFTIR;
   logic UPDATEIR;
   logic CAPTUREDR;
   logic SHIFTDR;
   logic UPDATEDR;
   logic TDO;
   logic TDO_EN;

   modport master (
      output TDI, TAP_RST, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR,
      input  TDO, TDO_EN
   );

   modport slave (
      input  TDI, TAP_RST, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR,
      output TDO, TDO_EN
   );

endinterface

// File: rtl/jtag_shift_reg.sv
// Capture/shift register: a parallel load on capture, a right shift with serial input at the MSB,
// and the full contents visible (bit 0 is the serial output).
module jtag_shift_reg
   import jtag_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             sin_i,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [WIDTH-1:0] shifted;

   if (WIDTH == 1) begin : g_w1
      assign shifted = sin_i;
   end else begin : g_wn
      assign shifted = {sin_i, sr_q[WIDTH-1:1]};
   end

   // Next value: capture takes priority over shift. Otherwise the register holds.
   always_comb begin
      sr_d = sr_q;
      if (capture_i) begin
         sr_d = pin_i;
      end else if (shift_i) begin
         sr_d = shifted;
      end
   end

   // State register with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q_o = sr_q;

endmodule

// File: rtl/jtag_tdr_bank.sv
// JTAG instruction register plus BYPASS/IDCODE/USER data registers and the TDO mux.
// Optional macro JTAG_TDR_SHIFT_COUNT_EN adds SHIFT_COUNT/COUNT_VALID.
module jtag_tdr_bank
   import jtag_pkg::*;
#(
   parameter int unsigned         IR_WIDTH   = 4,
   parameter int unsigned         USER_WIDTH = 32,
   parameter logic [31:0]         IDCODE_VAL = DEF_IDCODE,
   parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(jtag_pkg::OP_IDCODE),
   parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(jtag_pkg::OP_USER)
) (
   input  logic                  TCK,
   input  logic                  TRST,
   jtag_tdr_bank_if.slave        tap,
   output logic [IR_WIDTH-1:0]   IR_OUT,
   input  logic [USER_WIDTH-1:0] USER_DR_IN,
   output logic [USER_WIDTH-1:0] USER_DR_OUT,
   output logic                  USER_UPDATE
`ifdef JTAG_TDR_SHIFT_COUNT_EN
   ,
   output logic [15:0]           SHIFT_COUNT,
   output logic                  COUNT_VALID
`endif
);

   logic                  any_cap, any_sh;
   logic                  cap_ir, cap_dr, sh_ir, sh_dr, upd_ir, upd_dr;
   dr_sel_e               dr_sel;
   logic [IR_WIDTH-1:0]   ir_sr;
   logic [31:0]           idc_sr;
   logic [USER_WIDTH-1:0] user_sr;
   logic [IR_WIDTH-1:0]   ir_out_q;
   logic                  ir_path_q;
   logic                  byp_q;
   logic [USER_WIDTH-1:0] user_out_q;
   logic                  user_upd_q;
   logic                  tdo_q, tdo_d;
   logic                  unused_idc;

   // Collapse the strobes into one action per cycle (capture > shift > update).
   // TAP_RST low blocks every action.
   assign any_cap = tap.CAPTUREIR | tap.CAPTUREDR;
   assign any_sh  = tap.SHIFTIR | tap.SHIFTDR;
   assign cap_ir  = tap.TAP_RST & tap.CAPTUREIR;
   assign cap_dr  = tap.TAP_RST & tap.CAPTUREDR & ~tap.CAPTUREIR;
   assign sh_ir   = tap.TAP_RST & ~any_cap & tap.SHIFTIR;
   assign sh_dr   = tap.TAP_RST & ~any_cap & tap.SHIFTDR & ~tap.SHIFTIR;
   assign upd_ir  = tap.TAP_RST & ~any_cap & ~any_sh & tap.UPDATEIR;
   assign upd_dr  = tap.TAP_RST & ~any_cap & ~any_sh & tap.UPDATEDR & ~tap.UPDATEIR;

   // Decode the current instruction into a data register select. Unknown codes select BYPASS.
   always_comb begin
      dr_sel = SEL_BYPASS;
      if (ir_out_q == OP_IDCODE) begin
         dr_sel = SEL_IDCODE;
      end else if (ir_out_q == OP_USER) begin
         dr_sel = SEL_USER;
      end
   end

   jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
      .clk_i     (TCK),
      .rst_i     (TRST),
      .capture_i (cap_ir),
      .shift_i   (sh_ir),
      .sin_i     (tap.TDI),
      .pin_i     (IR_WIDTH'(IR_CAPTURE_PAT)),
      .q_o       (ir_sr)
   );

   jtag_shift_reg #(.WIDTH(32)) u_idcode (
      .clk_i     (TCK),
      .rst_i     (TRST),
      .capture_i (cap_dr & (dr_sel == SEL_IDCODE)),
      .shift_i   (sh_dr & (dr_sel == SEL_IDCODE)),
      .sin_i     (tap.TDI),
      .pin_i     (IDCODE_VAL),
      .q_o       (idc_sr)
   );

   jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_user (
      .clk_i     (TCK),
      .rst_i     (TRST),
      .capture_i (cap_dr & (dr_sel == SEL_USER)),
      .shift_i   (sh_dr & (dr_sel == SEL_USER)),
      .sin_i     (tap.TDI),
      .pin_i     (USER_DR_IN),
      .q_o       (user_sr)
   );

   // Only the serial output of IDCODE is observed.
   assign unused_idc = ^idc_sr[31:1];

   // Instruction, scan-path flag, bypass bit and USER parallel output.
   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir_out_q   <= OP_IDCODE;
         ir_path_q  <= 1'b0;
         byp_q      <= 1'b0;
         user_out_q <= '0;
         user_upd_q <= 1'b0;
      end else begin
         user_upd_q <= 1'b0;
         if (!tap.TAP_RST) begin
            ir_out_q  <= OP_IDCODE;
            ir_path_q <= 1'b0;
         end else begin
            if (cap_ir) begin
               ir_path_q <= 1'b1;
            end else if (cap_dr) begin
               ir_path_q <= 1'b0;
            end
            if (upd_ir) begin
               ir_out_q <= ir_sr;
            end
            if (cap_dr && dr_sel == SEL_BYPASS) begin
               byp_q <= 1'b0;
            end else if (sh_dr && dr_sel == SEL_BYPASS) begin
               byp_q <= tap.TDI;
            end
            if (upd_dr && dr_sel == SEL_USER) begin
               user_out_q <= user_sr;
               user_upd_q <= 1'b1;
            end
         end
      end
   end

   // Serial output source: the IR path after Capture-IR, otherwise the selected data register.
   always_comb begin
      tdo_d = byp_q;
      if (ir_path_q) begin
         tdo_d = ir_sr[0];
      end else if (dr_sel == SEL_IDCODE) begin
         tdo_d = idc_sr[0];
      end else if (dr_sel == SEL_USER) begin
         tdo_d = user_sr[0];
      end
   end

   // TDO is retimed on the falling edge so the bit is stable across the next rising edge.
   always_ff @(negedge TCK) begin
      if (TRST) begin
         tdo_q <= 1'b0;
      end else begin
         tdo_q <= tdo_d;
      end
   end

   assign tap.TDO     = tdo_q;
   assign tap.TDO_EN  = tap.SHIFTIR | tap.SHIFTDR;
   assign IR_OUT      = ir_out_q;
   assign USER_DR_OUT = user_out_q;
   assign USER_UPDATE = user_upd_q;

`ifdef JTAG_TDR_SHIFT_COUNT_EN
   logic [15:0] cnt_q;
   logic        cnt_valid_q;

   // Shift-cycle counter (saturating). It is valid from an update until the next capture.
   always_ff @(posedge TCK) begin
      if (TRST) begin
         cnt_q       <= '0;
         cnt_valid_q <= 1'b0;
      end else if (cap_ir || cap_dr) begin
         cnt_q       <= '0;
         cnt_valid_q <= 1'b0;
      end else begin
         if ((sh_ir || sh_dr) && cnt_q != '1) begin
            cnt_q <= cnt_q + 16'd1;
         end
         if (upd_ir || upd_dr) begin
            cnt_valid_q <= 1'b1;
         end
      end
   end

   assign SHIFT_COUNT = cnt_q;
   assign COUNT_VALID = cnt_valid_q;
`endif

endmodule
